// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues word reads to instruction memory over a
// req/gnt/rvalid handshake, buffers returned words with their PCs in a small
// FIFO and hands them to decode. An execute redirect flushes the buffer and
// drops any response still in flight.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr,
    input  logic            dec_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            gnt_accept;

    // A redirect cancels both the push of a returning word and a decode pop.
    assign push       = (state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pop        = (count != {CW{1'b0}}) && dec_ready && !redirect_valid;
    assign gnt_accept = (state == S_REQ) && imem_gnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a new request is only started while a FIFO slot is
    // free, so the single outstanding response always has room to land.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && (count < CW'(DEPTH))) begin
                    next_state = S_REQ;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    next_state = redirect_valid ? S_DROP : S_WAIT;
                end else begin
                    next_state = redirect_valid ? S_IDLE : S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_DROP;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Moore memory-side outputs decoded from the state register.
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = fetch_pc;
    end

    // Fetch PC tracking and capture of the PC belonging to the granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            req_pc   <= req_pc;
        end else if (gnt_accept) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            req_pc   <= fetch_pc;
        end else begin
            fetch_pc <= fetch_pc;
            req_pc   <= req_pc;
        end
    end

    // FIFO storage: write the returning word and its PC at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= {XLEN{1'b0}};
                fifo_instr[i] <= 32'd0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end else begin
            fifo_pc[wr_ptr]    <= fifo_pc[wr_ptr];
            fifo_instr[wr_ptr] <= fifo_instr[wr_ptr];
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= {AW{1'b0}};
            wr_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
        end else if (redirect_valid) begin
            rd_ptr <= {AW{1'b0}};
            wr_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode-side view of the FIFO head; fields read as zero when empty.
    always_comb begin
        dec_valid = (count != {CW{1'b0}});
        if (dec_valid) begin
            dec_pc    = fifo_pc[rd_ptr];
            dec_instr = fifo_instr[rd_ptr];
        end else begin
            dec_pc    = {XLEN{1'b0}};
            dec_instr = 32'd0;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: linear sequence of fetch, backpressure,
// redirect and reset scenarios with hand-computed expected values.
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;

    int checks = 0;
    int errors = 0;

    if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_ready      (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve the request currently on the bus: grant it, then respond next cycle.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        dec_ready      = 1'b0;

        // Reset state
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_instr", dec_instr, 32'h0);
        rst = 1'b0;

        // 1: first request one cycle after release, grant and respond
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        chk("t1_req_after_gnt", 32'(imem_req), 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        chk("t1_dec_valid", 32'(dec_valid), 32'd1);
        chk("t1_dec_pc", dec_pc, 32'h0);
        chk("t1_dec_instr", dec_instr, 32'h13);
        step();
        chk("t1_next_req", 32'(imem_req), 32'd1);
        chk("t1_next_addr", imem_addr, 32'h4);

        // 2: fill the FIFO with decode stalled, then drain in order
        fetch_one(32'h4, 32'h0000_00A4);
        step();
        fetch_one(32'h8, 32'h0000_00A8);
        step();
        fetch_one(32'hC, 32'h0000_00AC);
        step();
        chk("t2_full_noreq0", 32'(imem_req), 32'd0);
        step();
        chk("t2_full_noreq1", 32'(imem_req), 32'd0);
        chk("t2_full_addr", imem_addr, 32'h10);
        chk("t2_head0_pc", dec_pc, 32'h0);
        chk("t2_head0_instr", dec_instr, 32'h13);
        dec_ready = 1'b1;
        step();
        chk("t2_head1_pc", dec_pc, 32'h4);
        chk("t2_head1_instr", dec_instr, 32'hA4);
        step();
        chk("t2_head2_pc", dec_pc, 32'h8);
        chk("t2_head2_instr", dec_instr, 32'hA8);
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        step();
        chk("t2_head3_pc", dec_pc, 32'hC);
        chk("t2_head3_instr", dec_instr, 32'hAC);
        step();
        chk("t2_empty_valid", 32'(dec_valid), 32'd0);
        chk("t2_empty_pc", dec_pc, 32'h0);
        chk("t2_empty_instr", dec_instr, 32'h0);
        dec_ready = 1'b0;

        // 3: redirect while waiting; late response must be discarded
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        chk("t3_drop_req", 32'(imem_req), 32'd0);
        chk("t3_redir_addr", imem_addr, 32'h100);
        step();
        chk("t3_drop_hold_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        chk("t3_old_dropped", 32'(dec_valid), 32'd0);
        step();
        fetch_one(32'h100, 32'h0000_0033);
        chk("t3_new_valid", 32'(dec_valid), 32'd1);
        chk("t3_new_pc", dec_pc, 32'h100);
        chk("t3_new_instr", dec_instr, 32'h33);

        // 4: redirect coinciding with rvalid and a pop, two entries buffered
        step();
        fetch_one(32'h104, 32'h0000_0044);
        step();
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h108);
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h0000_0055;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        dec_ready      = 1'b1;
        step();
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        chk("t4_flush_valid", 32'(dec_valid), 32'd0);
        chk("t4_flush_pc", dec_pc, 32'h0);
        chk("t4_flush_instr", dec_instr, 32'h0);
        chk("t4_idle_req", 32'(imem_req), 32'd0);
        chk("t4_target_addr", imem_addr, 32'h200);
        step();
        chk("t4_new_req", 32'(imem_req), 32'd1);
        chk("t4_new_addr", imem_addr, 32'h200);
        chk("t4_still_empty", 32'(dec_valid), 32'd0);

        // 5: grant withheld; redirect withdraws the request for one cycle
        step();
        chk("t5_hold1_req", 32'(imem_req), 32'd1);
        chk("t5_hold1_addr", imem_addr, 32'h200);
        step();
        chk("t5_hold2_req", 32'(imem_req), 32'd1);
        chk("t5_hold2_addr", imem_addr, 32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0303;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        chk("t5_withdrawn_req", 32'(imem_req), 32'd0);
        chk("t5_withdrawn_addr", imem_addr, 32'h300);
        step();
        chk("t5_rereq", 32'(imem_req), 32'd1);
        chk("t5_rereq_addr", imem_addr, 32'h300);
        // Redirect on the grant edge: the granted response must be dropped
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        chk("t5_gnt_redir_req", 32'(imem_req), 32'd0);
        chk("t5_gnt_redir_addr", imem_addr, 32'h400);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0066;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        chk("t5_gnt_redir_drop", 32'(dec_valid), 32'd0);
        step();

        // 6: fill FIFO (decode stalled), then asynchronous reset mid-cycle
        dec_ready = 1'b0;
        fetch_one(32'h400, 32'h0000_0071);
        step();
        fetch_one(32'h404, 32'h0000_0072);
        step();
        fetch_one(32'h408, 32'h0000_0073);
        step();
        fetch_one(32'h40C, 32'h0000_0074);
        chk("t6_full_valid", 32'(dec_valid), 32'd1);
        chk("t6_full_pc", dec_pc, 32'h400);
        step();
        chk("t6_full_noreq", 32'(imem_req), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(dec_valid), 32'd0);
        chk("t6_async_req", 32'(imem_req), 32'd0);
        chk("t6_async_addr", imem_addr, 32'h0);
        chk("t6_async_pc", dec_pc, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_req", 32'(imem_req), 32'd1);
        chk("t6_post_addr", imem_addr, 32'h0);
        chk("t6_post_valid", 32'(dec_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
